// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among per-thread LSUs.
// Latches one read or write grant, relays it over valid/ready and returns the result.
module mem_channel_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int ID_BITS        = $clog2(NUM_REQUESTERS)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQUESTERS-1:0]                lsu_read_valid,
    input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] lsu_read_address,
    output logic [NUM_REQUESTERS-1:0]                lsu_read_ready,
    output logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] lsu_read_data,
    input  logic [NUM_REQUESTERS-1:0]                lsu_write_valid,
    input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] lsu_write_address,
    input  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] lsu_write_data,
    output logic [NUM_REQUESTERS-1:0]                lsu_write_ready,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready,
    output logic                                     busy
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t             state;
    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS-1:0] grant_id;
    logic               grant_is_read;

    logic               found;
    logic               win_read;
    logic [ID_BITS-1:0] win_id;
    logic [ID_BITS-1:0] idx;
    logic [ID_BITS-1:0] ptr_next;
    logic               released;
    int                 j;

    // Scan from rr_ptr with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        found    = 1'b0;
        win_read = 1'b0;
        win_id   = '0;
        idx      = '0;
        j        = 0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQUESTERS) j = j - NUM_REQUESTERS;
            idx = ID_BITS'(j);
            if (!found && (lsu_read_valid[idx] || lsu_write_valid[idx])) begin
                found    = 1'b1;
                win_id   = idx;
                win_read = lsu_read_valid[idx];
            end
        end
    end

    assign ptr_next = (grant_id == ID_BITS'(NUM_REQUESTERS - 1)) ?
                      '0 : grant_id + 1'b1;
    assign released = grant_is_read ? !lsu_read_valid[grant_id]
                                    : !lsu_write_valid[grant_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_id          <= '0;
            grant_is_read     <= 1'b0;
            lsu_read_ready    <= '0;
            lsu_read_data     <= '0;
            lsu_write_ready   <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            busy              <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_id      <= win_id;
                        grant_is_read <= win_read;
                        busy          <= 1'b1;
                        if (win_read) begin
                            mem_read_address <= lsu_read_address[win_id];
                            mem_read_valid   <= 1'b1;
                            state            <= READ_WAIT;
                        end else begin
                            mem_write_address <= lsu_write_address[win_id];
                            mem_write_data    <= lsu_write_data[win_id];
                            mem_write_valid   <= 1'b1;
                            state             <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        lsu_read_data[grant_id]  <= mem_read_data;
                        lsu_read_ready[grant_id] <= 1'b1;
                        mem_read_valid           <= 1'b0;
                        state                    <= RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        lsu_write_ready[grant_id] <= 1'b1;
                        mem_write_valid           <= 1'b0;
                        state                     <= RELAY;
                    end
                end
                RELAY: begin
                    // Hold the ready until the requester has seen it and dropped valid.
                    if (released) begin
                        lsu_read_ready  <= '0;
                        lsu_write_ready <= '0;
                        rr_ptr          <= ptr_next;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_channel_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      rv, wv, rr, wr;
    logic [3:0][7:0] ra, wa, wd, rd;
    logic            mem_rv, mem_rready, mem_wv, mem_wready, busy;
    logic [7:0]      mem_ra, mem_rdata, mem_wa, mem_wd;

    logic            t_reset;
    logic [2:0]      t_rv, t_wv, t_rr, t_wr;
    logic [2:0][7:0] t_ra, t_wa, t_wd, t_rd;
    logic            t_mrv, t_mrr, t_mwv, t_mwr, t_busy;
    logic [7:0]      t_mra, t_mrd, t_mwa, t_mwd;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_channel_arbiter dut (
        .clk(clk), .reset(reset),
        .lsu_read_valid(rv), .lsu_read_address(ra),
        .lsu_read_ready(rr), .lsu_read_data(rd),
        .lsu_write_valid(wv), .lsu_write_address(wa),
        .lsu_write_data(wd), .lsu_write_ready(wr),
        .mem_read_valid(mem_rv), .mem_read_address(mem_ra),
        .mem_read_ready(mem_rready), .mem_read_data(mem_rdata),
        .mem_write_valid(mem_wv), .mem_write_address(mem_wa),
        .mem_write_data(mem_wd), .mem_write_ready(mem_wready),
        .busy(busy)
    );

    mem_channel_arbiter #(.NUM_REQUESTERS(3)) u3 (
        .clk(clk), .reset(t_reset),
        .lsu_read_valid(t_rv), .lsu_read_address(t_ra),
        .lsu_read_ready(t_rr), .lsu_read_data(t_rd),
        .lsu_write_valid(t_wv), .lsu_write_address(t_wa),
        .lsu_write_data(t_wd), .lsu_write_ready(t_wr),
        .mem_read_valid(t_mrv), .mem_read_address(t_mra),
        .mem_read_ready(t_mrr), .mem_read_data(t_mrd),
        .mem_write_valid(t_mwv), .mem_write_address(t_mwa),
        .mem_write_data(t_mwd), .mem_write_ready(t_mwr),
        .busy(t_busy)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        rv = '0; wv = '0;
        mem_rready = 1'b0; mem_wready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic [3:0] wv;
        logic [2:0] ctrl;
        logic [7:0] ra;
        logic [7:0] wa;
        logic [7:0] wd;
    } vec_t;

    vec_t vt[7];

    // Reference model state for the randomized phase.
    bit         m_active, m_done, m_gr;
    int         m_g, m_ptr;
    logic [7:0] m_ra, m_wa, m_wd;
    logic [7:0] m_rdata[4];

    logic            ap_reset, ap_mrr, ap_mwr;
    logic [3:0]      ap_rv, ap_wv;
    logic [3:0][7:0] ap_ra, ap_wa, ap_wd;
    logic [7:0]      ap_mrdata;

    function automatic int scan(input int ptr, input logic [3:0] r,
                                input logic [3:0] w, output bit is_rd);
        is_rd = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (r[i] || w[i]) begin
                is_rd = r[i];
                return i;
            end
        end
        return -1;
    endfunction

    task automatic model_step;
        int w;
        bit is_rd;
        if (ap_reset) begin
            m_active = 0; m_done = 0; m_gr = 0; m_g = 0; m_ptr = 0;
            m_ra = '0; m_wa = '0; m_wd = '0;
            for (int i = 0; i < 4; i++) m_rdata[i] = '0;
        end else if (!m_active) begin
            w = scan(m_ptr, ap_rv, ap_wv, is_rd);
            if (w >= 0) begin
                m_active = 1; m_done = 0; m_g = w; m_gr = is_rd;
                if (is_rd) m_ra = ap_ra[w];
                else begin m_wa = ap_wa[w]; m_wd = ap_wd[w]; end
            end
        end else if (!m_done) begin
            if (m_gr ? ap_mrr : ap_mwr) begin
                m_done = 1;
                if (m_gr) m_rdata[m_g] = ap_mrdata;
            end
        end else if (!(m_gr ? ap_rv[m_g] : ap_wv[m_g])) begin
            m_active = 0;
            m_ptr = (m_g + 1) % 4;
        end
    endtask

    task automatic model_compare;
        logic [3:0] e_rr, e_wr;
        logic [2:0] e_ctrl;
        e_rr = (m_active && m_done && m_gr)  ? 4'(1 << m_g) : 4'b0;
        e_wr = (m_active && m_done && !m_gr) ? 4'(1 << m_g) : 4'b0;
        e_ctrl = {m_active && !m_done && m_gr,
                  m_active && !m_done && !m_gr, m_active};
        check("rand_ctrl", {mem_rv, mem_wv, busy, rr, wr},
              {e_ctrl, e_rr, e_wr});
        check("rand_addr", {mem_ra, mem_wa, mem_wd}, {m_ra, m_wa, m_wd});
        check("rand_rdata", rd,
              {m_rdata[3], m_rdata[2], m_rdata[1], m_rdata[0]});
    endtask

    task automatic drive_random;
        reset = ($urandom_range(0, 299) == 0);
        mem_rready = mem_rv ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 9) == 0);
        mem_wready = mem_wv ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 9) == 0);
        mem_rdata = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            if (rv[i]) begin
                if (rr[i] && $urandom_range(0, 1) == 1) rv[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                rv[i] = 1'b1;
                ra[i] = 8'($urandom);
            end
            if (wv[i]) begin
                if (wr[i] && $urandom_range(0, 1) == 1) wv[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                wv[i] = 1'b1;
                wa[i] = 8'($urandom);
                wd[i] = 8'($urandom);
            end
        end
    endtask

    initial begin
        int pulses;
        reset = 1'b1; rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        mem_rready = 1'b0; mem_wready = 1'b0; mem_rdata = '0;
        t_reset = 1'b1; t_rv = '0; t_wv = '0; t_ra = '0; t_wa = '0;
        t_wd = '0; t_mrr = 1'b0; t_mwr = 1'b0; t_mrd = '0;

        do_reset();
        check("reset_ctrl", {mem_rv, mem_wv, busy, rr, wr}, '0);
        check("reset_data", {mem_ra, mem_wa, mem_wd, rd}, '0);

        // Grant priority from a fresh reset (rr_ptr = 0).
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'(8'h40 + i);
            wa[i] = 8'(8'hC0 + i);
            wd[i] = 8'(8'h50 + i);
        end
        vt[0] = '{4'b0001, 4'b0000, 3'b101, 8'h40, 8'h00, 8'h00};
        vt[1] = '{4'b0100, 4'b0000, 3'b101, 8'h42, 8'h00, 8'h00};
        vt[2] = '{4'b0000, 4'b1000, 3'b011, 8'h00, 8'hC3, 8'h53};
        vt[3] = '{4'b0010, 4'b0010, 3'b101, 8'h41, 8'h00, 8'h00};
        vt[4] = '{4'b1000, 4'b0100, 3'b011, 8'h00, 8'hC2, 8'h52};
        vt[5] = '{4'b0000, 4'b0000, 3'b000, 8'h00, 8'h00, 8'h00};
        vt[6] = '{4'b1111, 4'b1111, 3'b101, 8'h40, 8'h00, 8'h00};
        for (int n = 0; n < 7; n++) begin
            do_reset();
            rv = vt[n].rv;
            wv = vt[n].wv;
            step();
            check($sformatf("vec%0d", n),
                  {mem_rv, mem_wv, busy, mem_ra, mem_wa, mem_wd},
                  {vt[n].ctrl, vt[n].ra, vt[n].wa, vt[n].wd});
        end

        // Single read from LSU2, memory answers after 3 cycles.
        do_reset();
        ra[2] = 8'h3C; ra[3] = 8'h33;
        rv = 4'b0100;
        pulses = 0;
        step();
        check("sr_grant", {mem_rv, mem_ra}, {1'b1, 8'h3C});
        for (int c = 0; c < 2; c++) begin
            step();
            pulses += int'(rr[2]);
        end
        mem_rready = 1'b1; mem_rdata = 8'hA5;
        step();
        mem_rready = 1'b0;
        pulses += int'(rr[2]);
        check("sr_done", {rr, mem_rv, rd[2]}, {4'b0100, 1'b0, 8'hA5});
        rv = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            pulses += int'(rr[2]);
        end
        check("sr_pulses", 64'(pulses), 64'd1);
        rv = 4'b1111;
        step();
        check("sr_next_ptr3", {mem_rv, mem_ra}, {1'b1, 8'h33});

        // Memory ready already high; LSU0 holds valid 3 cycles after ready.
        do_reset();
        ra = {8'h44, 8'h33, 8'h22, 8'h11};
        mem_rready = 1'b1; mem_rdata = 8'h99;
        rv = 4'b0001;
        step();
        check("hr_grant", {mem_rv, busy, mem_ra}, {2'b11, 8'h11});
        rv = 4'b0011;
        step();
        mem_rready = 1'b0;
        check("hr_done", {rr, mem_rv, busy, rd[0]},
              {4'b0001, 2'b01, 8'h99});
        for (int c = 0; c < 2; c++) begin
            step();
            check("hr_hold", {rr, mem_rv, mem_wv, busy},
                  {4'b0001, 3'b001});
        end
        rv = 4'b0010;
        step();
        check("hr_release", {rr, mem_rv, busy}, {4'b0000, 2'b00});
        step();
        check("hr_regrant", {mem_rv, mem_ra}, {1'b1, 8'h22});

        // Reset in READ_WAIT abandons the transfer and clears rr_ptr.
        do_reset();
        ra = {8'h3A, 8'h2A, 8'h1A, 8'h0A};
        mem_rready = 1'b1;
        rv = 4'b0001;
        step();
        step();
        rv = 4'b0000;
        step();
        mem_rready = 1'b0;
        rv = 4'b0010;
        step();
        check("mr_wait", {mem_rv, mem_ra}, {1'b1, 8'h1A});
        reset = 1'b1;
        rv = 4'b1001;
        step();
        reset = 1'b0;
        check("mr_cleared", {mem_rv, mem_wv, busy, rr, wr, rd}, '0);
        step();
        check("mr_regrant", {mem_rv, mem_ra}, {1'b1, 8'h0A});

        // Three requesters: wrap from rr_ptr = 2 back to 0.
        t_ra = {8'hB2, 8'hB1, 8'hB0};
        t_mrr = 1'b1;
        step();
        t_reset = 1'b0;
        t_rv = 3'b010;
        step();
        step();
        check("w3_first", {t_rr, t_mra}, {3'b010, 8'hB1});
        t_rv = 3'b000;
        step();
        t_rv = 3'b101;
        step();
        check("w3_lsu2", {t_mrv, t_mra}, {1'b1, 8'hB2});
        step();
        t_rv = 3'b001;
        check("w3_lsu2_done", t_rr, 3'b100);
        step();
        step();
        check("w3_lsu0", {t_mrv, t_mra}, {1'b1, 8'hB0});
        step();
        t_rv = 3'b000;
        step();
        t_rv = 3'b111;
        step();
        check("w3_ptr1", {t_mrv, t_mra}, {1'b1, 8'hB1});

        // Randomized traffic against the reference model.
        do_reset();
        rv = '0; wv = '0;
        ap_reset = 1'b1;
        model_step();
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            ap_reset = reset; ap_rv = rv; ap_wv = wv;
            ap_ra = ra; ap_wa = wa; ap_wd = wd;
            ap_mrr = mem_rready; ap_mwr = mem_wready; ap_mrdata = mem_rdata;
            step();
            model_step();
            model_compare();
            total++;
            if ((mem_rv && mem_wv) || ($countones({rr, wr}) > 1))
                $display("FAIL rand_exclusive: rv=%b wv=%b ready=%b",
                         mem_rv, mem_wv, {rr, wr});
            else passed++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
